// File: rtl/quadtest_oci_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : quadtest_oci_trace_pkg
// Purpose  : Shared types and sizing constants for the OCI DCT trace path.
// Revision : 1.0  initial release
// ============================================================================
package quadtest_oci_trace_pkg;

  localparam int ENTRY_W = 2;
  localparam int ENTRIES = 15;
  localparam int BUF_W   = ENTRY_W * ENTRIES;
  localparam int CNT_W   = 4;

  // Packer control states: normal packing, end-of-test drain, terminal.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ENDED = 2'd2
  } dct_state_t;

  typedef logic [ENTRY_W-1:0] dct_code_t;

endpackage
`default_nettype wire

// File: rtl/quadtest_oci_dct_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : quadtest_oci_dct_out_reg
// Purpose  : Single-entry valid/ready holding register. Payload is held
//            stable while valid and not ready; o_slot_free tells the producer
//            it may load this cycle (empty, or emptying this cycle).
// Revision : 1.0  initial release
// ============================================================================
module quadtest_oci_dct_out_reg #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  input  logic         i_out_ready,
  output logic         o_out_valid,
  output logic [W-1:0] o_out_data,
  output logic         o_slot_free
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_slot_free = !r_valid || i_out_ready;
  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;

  // Load a new payload when the slot frees up, otherwise retire on hand-off.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load && o_slot_free) begin
      r_valid <= 1'b1;
      r_data  <= i_load_data;
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/quadtest_cpu_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : quadtest_cpu_oci_dct_packer
// Purpose  : Packs 2-bit DCT codes into 30-bit frames with an entry count and
//            hands them downstream over valid/ready; drains on end of test.
// Revision : 1.0  initial release
// ============================================================================
module quadtest_cpu_oci_dct_packer #(
  parameter  int ENTRY_W = 2,
  parameter  int ENTRIES = 15,
  parameter  int CNT_W   = 4,
  parameter  int FCNT_W  = 16,
  localparam int BUF_W   = ENTRY_W * ENTRIES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ENTRY_W-1:0] in_code,
  input  logic               flush,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               test_ending,
  output logic               test_has_ended,
  output logic [FCNT_W-1:0]  frames_sent
);

  import quadtest_oci_trace_pkg::*;

  localparam logic [CNT_W-1:0] c_full = CNT_W'(ENTRIES);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  dct_state_t               r_state, w_state_nxt;
  logic [BUF_W-1:0]         r_acc, w_acc_nxt;
  logic [CNT_W-1:0]         r_acc_cnt, w_cnt_nxt;
  logic                     r_flush_pend, w_flush_nxt;
  logic [FCNT_W-1:0]        r_frames;

  logic                     w_slot_free;
  logic                     w_accept;
  logic                     w_xfer;
  logic [BUF_W+CNT_W-1:0]   w_out_data;

  assign in_ready = !reset && (r_state == RUN) && ((r_acc_cnt != c_full) || w_slot_free);
  assign w_accept = in_valid && in_ready;

  // Move the accumulator out when it is full, flushed, or being drained.
  assign w_xfer = w_slot_free && (r_acc_cnt != '0) &&
                  ((r_acc_cnt == c_full) || r_flush_pend || (r_state == DRAIN));

  assign test_has_ended = (r_state == ENDED);
  assign frames_sent    = r_frames;
  assign dct_buffer     = w_out_data[BUF_W+CNT_W-1:CNT_W];
  assign dct_count      = w_out_data[CNT_W-1:0];

  quadtest_oci_dct_out_reg #(
    .W (BUF_W + CNT_W)
  ) u_out_reg (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_xfer),
    .i_load_data ({r_acc, r_acc_cnt}),
    .i_out_ready (out_ready),
    .o_out_valid (out_valid),
    .o_out_data  (w_out_data),
    .o_slot_free (w_slot_free)
  );

  // Accumulator next value: shift in on accept, restart with the new code
  // when a transfer empties the accumulator in the same cycle.
  always_comb begin
    w_acc_nxt = r_acc;
    w_cnt_nxt = r_acc_cnt;
    if (w_xfer) begin
      w_acc_nxt = '0;
      w_cnt_nxt = '0;
    end
    if (w_accept) begin
      if (w_xfer) begin
        w_acc_nxt = {{(BUF_W-ENTRY_W){1'b0}}, in_code};
        w_cnt_nxt = c_one;
      end else begin
        w_acc_nxt = {r_acc[BUF_W-ENTRY_W-1:0], in_code};
        w_cnt_nxt = r_acc_cnt + c_one;
      end
    end
  end

  // Pending flush survives until its frame moves out; an empty accumulator
  // drops it so no zero-length frame is produced. A flush that arrives while
  // another frame transfers applies to the code accepted alongside it.
  always_comb begin
    if (w_xfer) begin
      w_flush_nxt = flush && w_accept;
    end else begin
      w_flush_nxt = (flush || r_flush_pend) && ((r_acc_cnt != '0) || w_accept);
    end
  end

  // End-of-test sequencing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (test_ending) w_state_nxt = DRAIN;
      DRAIN:   if ((r_acc_cnt == '0) && !out_valid) w_state_nxt = ENDED;
      ENDED:   w_state_nxt = ENDED;
      default: w_state_nxt = RUN;
    endcase
  end

  // State, accumulator and flush registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_acc        <= '0;
      r_acc_cnt    <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_acc_cnt    <= w_cnt_nxt;
      r_flush_pend <= w_flush_nxt;
    end
  end

  // Saturating count of frames handed downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frames <= '0;
    end else if (out_valid && out_ready && (r_frames != '1)) begin
      r_frames <= r_frames + FCNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_quadtest_cpu_oci_dct_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_quadtest_cpu_oci_dct_packer
// Purpose  : Scoreboard bench for the DCT packer.
// Revision : 1.0  initial release
// ============================================================================
module tb_quadtest_cpu_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_code;
  logic        flush;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        out_valid;
  logic        out_ready;
  logic        test_ending;
  logic        test_has_ended;
  logic [15:0] frames_sent;

  int          total = 0;
  int          bad   = 0;
  int          n_acc = 0;
  int          stalls = 0;
  logic [33:0] sb[$];
  logic [33:0] mon_exp;
  logic [33:0] held;
  logic        hold_prev = 1'b0;

  quadtest_cpu_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_code        (in_code),
    .flush          (flush),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .frames_sent    (frames_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one code and wait (bounded) until it is accepted.
  task automatic send_code(input logic [1:0] c);
    int  waits = 0;
    logic done = 1'b0;
    in_valid = 1'b1;
    in_code  = c;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        n_acc++;
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        waits++;
        stalls++;
        if (waits > 200) begin
          total++;
          bad++;
          $display("FAIL accept_timeout: got no accept in %0d cycles expected accept", waits);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      tick(1);
      n++;
    end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  // Monitor: compare every hand-off against the scoreboard and verify the
  // payload stays put while back-pressured.
  always @(negedge clk) begin
    if (hold_prev && !reset) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", {dct_buffer, dct_count}, held);
    end
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: got %0h expected none", {dct_buffer, dct_count});
      end else begin
        mon_exp = sb.pop_front();
        check("frame", {dct_buffer, dct_count}, mon_exp);
      end
    end
    hold_prev = !reset && out_valid && !out_ready;
    held      = {dct_buffer, dct_count};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_code     = 2'd0;
    flush       = 1'b0;
    out_ready   = 1'b1;
    test_ending = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_buffer", dct_buffer, 0);
    check("rst_count", dct_count, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_ended", test_has_ended, 0);
    check("rst_frames", frames_sent, 0);
    reset = 1'b0;
    #1;
    check("run_in_ready", in_ready, 1);
    tick(1);

    // 1: full frame of 0,1,2,3,...
    sb.push_back({30'h06C6C6C6, 4'd15});
    for (int i = 0; i < 15; i++) send_code(2'(i % 4));
    wait_drain();
    check("t1_frames", frames_sent, 1);

    // 2: partial frame via flush, then flush with nothing pending
    sb.push_back({30'h39, 4'd3});
    send_code(2'd3);
    send_code(2'd2);
    send_code(2'd1);
    pulse_flush();
    wait_drain();
    check("t2_frames", frames_sent, 2);
    pulse_flush();
    tick(5);
    check("t2_empty_flush_valid", out_valid, 0);
    check("t2_empty_flush_frames", frames_sent, 2);

    // 3: back-pressure with 40 codes offered
    sb.push_back({30'h06C6C6C6, 4'd15});
    sb.push_back({30'h31B1B1B1, 4'd15});
    sb.push_back({30'h000B1B1B, 4'd10});
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) send_code(2'(i % 4));
      end
      begin
        out_ready = 1'b0;
        tick(40);
        check("t3_accepted", n_acc, 30);
        check("t3_in_ready_low", in_ready, 0);
        check("t3_held_valid", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    pulse_flush();
    wait_drain();
    check("t3_frames", frames_sent, 5);

    // 4: 45 continuous codes, no bubbles
    stalls = 0;
    sb.push_back({30'h3FFFFFFF, 4'd15});
    sb.push_back({30'h15555555, 4'd15});
    sb.push_back({30'h2AAAAAAA, 4'd15});
    for (int i = 0; i < 15; i++) send_code(2'd3);
    for (int i = 0; i < 15; i++) send_code(2'd1);
    for (int i = 0; i < 15; i++) send_code(2'd2);
    check("t4_stalls", stalls, 0);
    wait_drain();
    check("t4_frames", frames_sent, 8);

    // 5: end-of-test drain of a 7-code partial frame
    check("t5_not_ended", test_has_ended, 0);
    sb.push_back({30'h00001B6D, 4'd7});
    send_code(2'd1); send_code(2'd2); send_code(2'd3); send_code(2'd1);
    send_code(2'd2); send_code(2'd3); send_code(2'd1);
    test_ending = 1'b1;
    tick(1);
    check("t5_in_ready_low", in_ready, 0);
    begin
      int n = 0;
      while (!test_has_ended && n < 20) begin
        tick(1);
        n++;
      end
    end
    check("t5_ended", test_has_ended, 1);
    check("t5_queue_empty", sb.size(), 0);
    check("t5_frames", frames_sent, 9);
    test_ending = 1'b0;
    in_valid    = 1'b1;
    tick(5);
    check("t5_ended_sticky", test_has_ended, 1);
    check("t5_ended_in_ready", in_ready, 0);
    in_valid = 1'b0;

    // 6: reset with a held frame and 9 codes accumulated
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("t6_run_again", test_has_ended, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 24; i++) send_code(2'(i % 4));
    check("t6_held_valid", out_valid, 1);
    check("t6_held_count", dct_count, 15);
    reset = 1'b1;
    tick(1);
    check("t6_out_valid", out_valid, 0);
    check("t6_buffer", dct_buffer, 0);
    check("t6_count", dct_count, 0);
    check("t6_frames", frames_sent, 0);
    check("t6_ended", test_has_ended, 0);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t6_in_ready", in_ready, 1);
    tick(5);
    check("t6_dropped", out_valid, 0);
    check("final_queue_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
